// File: rtl/serial_sub.sv
// Bit-serial subtractor: LSB-first ripple-borrow over WIDTH clock cycles.
// Optional SERIAL_SUB_OVF_EN adds a registered signed-overflow flag (ovf_out).
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out,
  output logic             busy_out,
  output logic             done_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf_out
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             d;
  logic             br_next;
  logic             last_bit;

  // One full-subtractor cell applied to the current LSBs of the operand registers.
  always_comb begin
    d        = a_sh[0] ^ b_sh[0] ^ br;
    br_next  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    last_bit = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_sh       <= '0;
      b_sh       <= '0;
      res_sh     <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      diff_out   <= '0;
      borrow_out <= 1'b0;
      busy_out   <= 1'b0;
      done_out   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_out    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done_out <= 1'b0;
          if (start_in) begin
            a_sh     <= a_in;
            b_sh     <= b_in;
            br       <= 1'b0;
            cnt      <= '0;
            busy_out <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          res_sh <= {d, res_sh[WIDTH-1:1]};
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          br     <= br_next;
          cnt    <= cnt + CW'(1);
          if (last_bit) begin
            diff_out   <= {d, res_sh[WIDTH-1:1]};
            borrow_out <= br_next;
`ifdef SERIAL_SUB_OVF_EN
            // On the last bit the operand LSBs are the original sign bits and d is the result sign.
            ovf_out    <= (a_sh[0] ^ b_sh[0]) & (d ^ a_sh[0]);
`endif
            busy_out   <= 1'b0;
            done_out   <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          done_out <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy_out <= 1'b0;
          done_out <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Directed testbench for serial_sub (WIDTH=8); covers ovf_out when SERIAL_SUB_OVF_EN is defined.
module tb_serial_sub;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start_in;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] diff_out;
  logic             borrow_out;
  logic             busy_out;
  logic             done_out;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_out;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Expected results, packed as {ovf, borrow, diff}.
  logic [WIDTH+1:0] exp_q[$];

  serial_sub #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_in   (start_in),
    .a_in       (a_in),
    .b_in       (b_in),
    .diff_out   (diff_out),
    .borrow_out (borrow_out),
    .busy_out   (busy_out),
    .done_out   (done_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf_out    (ovf_out)
`endif
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pops the oldest expected result and compares it with the registered outputs.
  task automatic check_result(input string tag);
    logic [WIDTH+1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_diff"}, 32'(diff_out), 32'(e[WIDTH-1:0]));
      check({tag, "_borrow"}, 32'(borrow_out), 32'(e[WIDTH]));
`ifdef SERIAL_SUB_OVF_EN
      check({tag, "_ovf"}, 32'(ovf_out), 32'(e[WIDTH+1]));
`endif
    end
  endtask

  // Waits (bounded) for done_out at negedges; returns cycles waited and busy samples seen.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (!done_out && lat < 20) begin
      if (busy_out) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  // Called at a negedge in IDLE; the next rising edge is the accepting edge.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] exp_diff, input logic exp_borrow, input logic exp_ovf);
    int lat;
    int busy_cnt;
    exp_q.push_back({exp_ovf, exp_borrow, exp_diff});
    a_in = a;
    b_in = b;
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    a_in = ~a;
    b_in = ~b;
    wait_done(lat, busy_cnt);
    check({tag, "_latency"}, 32'(lat), 32'd8);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd8);
    check({tag, "_busy_at_done"}, 32'(busy_out), 32'd0);
    check_result(tag);
    @(negedge clk);
    check({tag, "_done_pulse_end"}, 32'(done_out), 32'd0);
    check({tag, "_diff_hold"}, 32'(diff_out), 32'(exp_diff));
  endtask

  initial begin : stim
    int lat;
    int busy_cnt;
    int pulses;
    int t1;
    int t2;
    logic [WIDTH-1:0] seen_diff;
    logic             seen_borrow;

    // Reset
    rst_n = 1'b0;
    start_in = 1'b0;
    a_in = '0;
    b_in = '0;
    repeat (3) @(negedge clk);
    check("reset_diff", 32'(diff_out), 32'd0);
    check("reset_borrow", 32'(borrow_out), 32'd0);
    check("reset_busy", 32'(busy_out), 32'd0);
    check("reset_done", 32'(done_out), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("reset_ovf", 32'(ovf_out), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors
    run_op("sub_05_03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    run_op("sub_03_05", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
    run_op("sub_ff_ff", 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);
    run_op("sub_80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    run_op("sub_10_01", 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0);

    // Idle with start low holds outputs
    repeat (3) @(negedge clk);
    check("idle_hold_diff", 32'(diff_out), 32'h0F);
    check("idle_busy_low", 32'(busy_out), 32'd0);

    // start pulse and input changes during SHIFT are ignored
    a_in = 8'h05;
    b_in = 8'h03;
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    repeat (2) @(negedge clk);
    start_in = 1'b1;
    a_in = 8'hAA;
    b_in = 8'h11;
    @(negedge clk);
    start_in = 1'b0;
    a_in = 8'h3C;
    b_in = 8'hC3;
    pulses = 0;
    seen_diff = '0;
    seen_borrow = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (done_out) begin
        pulses++;
        seen_diff = diff_out;
        seen_borrow = borrow_out;
      end
      @(negedge clk);
    end
    check("ignore_start_pulses", 32'(pulses), 32'd1);
    check("ignore_start_diff", 32'(seen_diff), 32'h02);
    check("ignore_start_borrow", 32'(seen_borrow), 32'd0);

    // Async reset in the middle of SHIFT
    a_in = 8'h05;
    b_in = 8'h03;
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_busy", 32'(busy_out), 32'd0);
    check("midreset_diff", 32'(diff_out), 32'd0);
    check("midreset_borrow", 32'(borrow_out), 32'd0);
    check("midreset_done", 32'(done_out), 32'd0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done_out) pulses++;
      if (i == 2) rst_n = 1'b1;
      if (i == 2) start_in = 1'b0;
    end
    check("midreset_no_done", 32'(pulses), 32'd0);
    check("midreset_diff_after", 32'(diff_out), 32'd0);
    // New start exactly at the first edge after release
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_reset_03_05", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);

    // Back-to-back with start held high
    exp_q.push_back({1'b0, 1'b1, 8'hE2});
    exp_q.push_back({1'b1, 1'b1, 8'hFF});
    a_in = 8'h3C;
    b_in = 8'h5A;
    start_in = 1'b1;
    @(negedge clk);
    a_in = 8'h7F;
    b_in = 8'h80;
    wait_done(lat, busy_cnt);
    check("b2b_first_latency", 32'(lat), 32'd8);
    t1 = cyc;
    check_result("b2b_first");
    @(negedge clk);
    wait_done(lat, busy_cnt);
    t2 = cyc;
    check("b2b_period", 32'(t2 - t1), 32'd10);
    check_result("b2b_second");
    start_in = 1'b0;
    repeat (2) @(negedge clk);
    check("b2b_final_busy", 32'(busy_out), 32'd0);
    check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
